// File: rtl/rat_port_timer.sv
// RAT MCU port-mapped countdown timer with level interrupt, owning four port IDs from BASE_ID.
// Define RAT_TIMER_PRESCALE_EN to build the 12-bit prescaler and the CTRL.PSC field.
module rat_port_timer #(
    parameter logic [7:0] BASE_ID = 8'h40
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       IO_STRB,
    output logic [7:0] IN_PORT,
    output logic       IN_SEL,
    output logic       INTERRUPT
);

    localparam logic [1:0] OFS_CTRL   = 2'd0;
    localparam logic [1:0] OFS_RELOAD = 2'd1;
    localparam logic [1:0] OFS_COUNT  = 2'd2;
    localparam logic [1:0] OFS_STATUS = 2'd3;

    logic       r_en;
    logic       r_auto;
    logic       r_ie;
    logic [7:0] r_reload;
    logic [7:0] r_count;
    logic       r_expired;

    logic       w_sel;
    logic       w_wr;
    logic       w_wr_ctrl;
    logic       w_wr_reload;
    logic       w_wr_count;
    logic       w_wr_status;
    logic       w_tick;
    logic       w_expire;
    logic [1:0] w_psc_rd;
    logic [7:0] w_rd_data;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign w_sel       = (PORT_ID[7:2] == BASE_ID[7:2]);
    assign w_wr        = IO_STRB & w_sel;
    assign w_wr_ctrl   = w_wr & (PORT_ID[1:0] == OFS_CTRL);
    assign w_wr_reload = w_wr & (PORT_ID[1:0] == OFS_RELOAD);
    assign w_wr_count  = w_wr & (PORT_ID[1:0] == OFS_COUNT);
    assign w_wr_status = w_wr & (PORT_ID[1:0] == OFS_STATUS);

    // ------------------------------------------------------------------
    // Tick generation
    // ------------------------------------------------------------------
`ifdef RAT_TIMER_PRESCALE_EN
    logic [1:0]  r_psc;
    logic [11:0] r_presc;
    logic [11:0] w_term;
    logic        w_unused;

    assign w_unused = ^{OUT_PORT[7:6], OUT_PORT[3]};

    always_comb begin
        w_term = 12'h000;
        case (r_psc)
            2'd0:    w_term = 12'h000;
            2'd1:    w_term = 12'h00F;
            2'd2:    w_term = 12'h0FF;
            default: w_term = 12'hFFF;
        endcase
    end

    assign w_tick   = r_en & (r_presc == w_term);
    assign w_psc_rd = r_psc;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_psc <= 2'd0;
        end else if (w_wr_ctrl) begin
            r_psc <= OUT_PORT[5:4];
        end
    end

    // A CTRL write restarts the prescale interval so the first tick is a full period away.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_presc <= 12'd0;
        end else if (!r_en || w_wr_ctrl || w_tick) begin
            r_presc <= 12'd0;
        end else begin
            r_presc <= r_presc + 12'd1;
        end
    end
`else
    logic w_unused;

    assign w_unused = ^{OUT_PORT[7:3]};
    assign w_tick   = r_en;
    assign w_psc_rd = 2'b00;
`endif

    assign w_expire = w_tick & (r_count == 8'd0);

    // ------------------------------------------------------------------
    // Control register
    // ------------------------------------------------------------------
    // A CPU write to CTRL takes priority over the one-shot EN clear.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_en   <= 1'b0;
            r_auto <= 1'b0;
            r_ie   <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_en   <= OUT_PORT[0];
            r_auto <= OUT_PORT[1];
            r_ie   <= OUT_PORT[2];
        end else if (w_expire && !r_auto) begin
            r_en   <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_reload <= 8'd0;
        end else if (w_wr_reload) begin
            r_reload <= OUT_PORT;
        end
    end

    // ------------------------------------------------------------------
    // Counter
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_count <= 8'd0;
        end else if (w_wr_count) begin
            r_count <= OUT_PORT;
        end else if (w_tick) begin
            if (r_count != 8'd0) begin
                r_count <= r_count - 8'd1;
            end else if (r_auto) begin
                r_count <= r_reload;
            end
        end
    end

    // A new expiry outranks a simultaneous W1C so no event is dropped.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_expired <= 1'b0;
        end else if (w_expire) begin
            r_expired <= 1'b1;
        end else if (w_wr_status && OUT_PORT[0]) begin
            r_expired <= 1'b0;
        end
    end

    assign INTERRUPT = r_expired & r_ie;

    // ------------------------------------------------------------------
    // Combinational read path
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_data = 8'h00;
        if (w_sel) begin
            case (PORT_ID[1:0])
                OFS_CTRL:   w_rd_data = {2'b00, w_psc_rd, 1'b0, r_ie, r_auto, r_en};
                OFS_RELOAD: w_rd_data = r_reload;
                OFS_COUNT:  w_rd_data = r_count;
                default:    w_rd_data = {6'b0, r_en, r_expired};
            endcase
        end
    end

    assign IN_PORT = w_rd_data;
    assign IN_SEL  = w_sel;

endmodule

// File: tb/tb_rat_port_timer.sv
// Directed bench for rat_port_timer: register access, auto/one-shot counting, collisions, prescale, reset.
`timescale 1ns/1ps
module tb_rat_port_timer;

  logic       clk;
  logic       rst;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       io_strb;
  logic [7:0] in_port;
  logic       in_sel;
  logic       interrupt;

  int n_pass;
  int n_total;

  rat_port_timer #(.BASE_ID(8'h40)) dut (
    .CLK       (clk),
    .RESET     (rst),
    .PORT_ID   (port_id),
    .OUT_PORT  (out_port),
    .IO_STRB   (io_strb),
    .IN_PORT   (in_port),
    .IN_SEL    (in_sel),
    .INTERRUPT (interrupt)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic wr(input logic [7:0] id, input logic [7:0] d);
    port_id  = id;
    out_port = d;
    io_strb  = 1'b1;
    @(posedge clk);
    #1;
    io_strb  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] id, input logic [7:0] exp, input string tag);
    port_id = id;
    #1;
    check(tag, in_port, exp);
  endtask

  task automatic chk_sel(input logic [7:0] id, input logic exp, input string tag);
    port_id = id;
    #1;
    check(tag, {7'b0, in_sel}, {7'b0, exp});
  endtask

  task automatic chk_int(input logic exp, input string tag);
    check(tag, {7'b0, interrupt}, {7'b0, exp});
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    rst      = 1'b1;
    port_id  = 8'h00;
    out_port = 8'h00;
    io_strb  = 1'b0;
    repeat (2) @(posedge clk);
    #10 rst = 1'b0;
    step();

    // reset state
    rd(8'h40, 8'h00, "rst_ctrl");
    rd(8'h41, 8'h00, "rst_reload");
    rd(8'h42, 8'h00, "rst_count");
    rd(8'h43, 8'h00, "rst_status");
    chk_int(1'b0, "rst_int");
    chk_sel(8'h40, 1'b1, "sel_40");
    chk_sel(8'h43, 1'b1, "sel_43");
    chk_sel(8'h44, 1'b0, "sel_44");
    rd(8'h44, 8'h00, "rd_44");

    // auto-reload, RELOAD=3: period of 4 ticks
    wr(8'h41, 8'h03);
    wr(8'h42, 8'h03);
    wr(8'h40, 8'h07);
    rd(8'h42, 8'h03, "auto_cnt_n");
    rd(8'h40, 8'h07, "auto_ctrl");
    rd(8'h41, 8'h03, "auto_reload");
    rd(8'h43, 8'h02, "auto_status_n");
    chk_int(1'b0, "auto_int_n");
    chk_sel(8'h46, 1'b0, "sel_46_busy");
    rd(8'h46, 8'h00, "rd_46_busy");
    step();
    rd(8'h42, 8'h02, "auto_cnt_1");
    step();
    rd(8'h42, 8'h01, "auto_cnt_2");
    step();
    rd(8'h42, 8'h00, "auto_cnt_3");
    chk_int(1'b0, "auto_int_3");
    rd(8'h43, 8'h02, "auto_status_3");
    step();
    rd(8'h42, 8'h03, "auto_cnt_reload");
    chk_int(1'b1, "auto_int_rise");
    rd(8'h43, 8'h03, "auto_status_exp");
    step();
    rd(8'h42, 8'h02, "auto_cnt_5");
    chk_int(1'b1, "auto_int_hold");

    // W1C clears EXPIRED
    wr(8'h43, 8'h01);
    chk_int(1'b0, "w1c_int");
    rd(8'h43, 8'h02, "w1c_status");
    rd(8'h42, 8'h01, "w1c_cnt");
    step();
    rd(8'h42, 8'h00, "pre_coll_cnt");

    // W1C on the same edge as an expiry: set wins
    wr(8'h43, 8'h01);
    rd(8'h43, 8'h03, "coll_w1c_status");
    chk_int(1'b1, "coll_w1c_int");
    rd(8'h42, 8'h03, "coll_w1c_cnt");

    // COUNT write on a tick edge: write wins
    wr(8'h42, 8'h55);
    rd(8'h42, 8'h55, "coll_cnt_wr");
    step();
    rd(8'h42, 8'h54, "coll_cnt_next");

    wr(8'h40, 8'h00);
    wr(8'h43, 8'h01);
    chk_int(1'b0, "stop_int");
    rd(8'h43, 8'h00, "stop_status");
    rd(8'h42, 8'h53, "stop_cnt");
    step();
    rd(8'h42, 8'h53, "stop_cnt_held");

    // one-shot: COUNT=2 expires after 3 ticks and clears EN
    wr(8'h42, 8'h02);
    wr(8'h40, 8'h05);
    rd(8'h40, 8'h05, "os_ctrl");
    step();
    rd(8'h42, 8'h01, "os_cnt_1");
    step();
    rd(8'h42, 8'h00, "os_cnt_2");
    rd(8'h43, 8'h02, "os_status_2");
    step();
    rd(8'h43, 8'h01, "os_status_exp");
    rd(8'h40, 8'h04, "os_ctrl_end");
    rd(8'h42, 8'h00, "os_cnt_end");
    chk_int(1'b1, "os_int");
    step();
    rd(8'h42, 8'h00, "os_cnt_stay");
    rd(8'h43, 8'h01, "os_status_stay");

    // CTRL write on the one-shot EN-clear edge: write wins
    wr(8'h43, 8'h01);
    wr(8'h40, 8'h05);
    wr(8'h40, 8'h05);
    rd(8'h40, 8'h05, "coll_ctrl");
    rd(8'h43, 8'h03, "coll_ctrl_status");
    wr(8'h40, 8'h00);
    wr(8'h43, 8'h01);
    rd(8'h43, 8'h00, "coll_ctrl_clr");

    // prescaler / no-prescaler tick rate
    wr(8'h42, 8'h01);
    wr(8'h40, 8'h11);
`ifdef RAT_TIMER_PRESCALE_EN
    rd(8'h40, 8'h11, "psc_ctrl");
    repeat (15) step();
    rd(8'h42, 8'h01, "psc_cnt_15");
    step();
    rd(8'h42, 8'h00, "psc_cnt_16");
`else
    rd(8'h40, 8'h01, "psc_ctrl");
    rd(8'h42, 8'h01, "psc_cnt_0");
    step();
    rd(8'h42, 8'h00, "psc_cnt_1");
`endif
    wr(8'h40, 8'h00);
    wr(8'h43, 8'h01);

    // asynchronous reset mid-count with INTERRUPT high
    wr(8'h41, 8'h22);
    wr(8'h42, 8'h00);
    wr(8'h40, 8'h07);
    step();
    chk_int(1'b1, "prerst_int");
    rd(8'h42, 8'h22, "prerst_cnt");
    step();
    rd(8'h42, 8'h21, "prerst_cnt2");
    #20 rst = 1'b1;
    #1;
    chk_int(1'b0, "arst_int");
    rd(8'h40, 8'h00, "arst_ctrl");
    rd(8'h41, 8'h00, "arst_reload");
    rd(8'h42, 8'h00, "arst_count");
    rd(8'h43, 8'h00, "arst_status");
    #5 rst = 1'b0;
    step();
    rd(8'h42, 8'h00, "post_rst_cnt");
    chk_int(1'b0, "post_rst_int");

    // out-of-range writes change nothing
    wr(8'h44, 8'hFF);
    wr(8'h3F, 8'hFF);
    wr(8'h47, 8'hFF);
    chk_sel(8'h3F, 1'b0, "sel_3f");
    rd(8'h40, 8'h00, "oor_ctrl");
    rd(8'h41, 8'h00, "oor_reload");
    rd(8'h42, 8'h00, "oor_count");
    rd(8'h43, 8'h00, "oor_status");
    chk_int(1'b0, "oor_int");

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rat_port_timer.md
# rat_port_timer

Port-mapped countdown timer and interrupt source that sits on the RAT MCU I/O bus as a responder. It decodes the MCU's PORT_ID/IO_STRB write strobes and captures OUT_PORT into control registers. It returns register contents on a combinational read path for IN instructions, and raises the MCU INTERRUPT input on timer expiry. Multiple instances coexist on one bus by giving each a distinct BASE_ID.

## Interface
- BASE_ID, 8'h40, first of four consecutive port IDs owned by this block; must be 4-aligned.
- CLK  in  1  system clock, rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- PORT_ID  in  8  port address from MCU.
- OUT_PORT  in  8  write data from MCU.
- IO_STRB  in  1  write strobe from MCU; a write occurs on every rising CLK edge with IO_STRB=1 and PORT_ID in range.
- IN_PORT  out  8  read data; combinational; 8'h00 when PORT_ID is not in range.
- IN_SEL  out  1  combinational; 1 when PORT_ID[7:2]==BASE_ID[7:2]; system IN_PORT mux select.
- INTERRUPT  out  1  level interrupt to MCU.

## Operation
- Register map (offset = PORT_ID[1:0]):
  - 0 CTRL (R/W): bit0 EN, bit1 AUTO (auto-reload), bit2 IE, bits[5:4] PSC, others read 0.
  - 1 RELOAD (R/W): 8-bit reload value.
  - 2 COUNT (R/W): current count; write loads COUNT directly.
  - 3 STATUS: read {6'b0, EN, EXPIRED}; write with OUT_PORT[0]=1 clears EXPIRED (W1C); other bits ignored.
- Reads have no side effects.
- Tick generation: a 12-bit prescaler runs only while EN=1 and is held at 0 while EN=0 or on any CTRL write. A tick fires when the prescaler reaches its terminal value: PSC 0/1/2/3 gives one tick per 1/16/256/4096 cycles.
- On each tick:
  - COUNT!=0: COUNT <= COUNT-1.
  - COUNT==0: EXPIRED <= 1. If AUTO=1, COUNT <= RELOAD; otherwise EN <= 0 (one-shot end) and COUNT stays 0.
- Period in auto mode = (RELOAD+1) ticks. RELOAD=0 expires on every tick.
- INTERRUPT = EXPIRED & IE, an AND of two flops with no glitch path. It stays asserted until software clears EXPIRED or IE.
- Writing RELOAD does not touch COUNT; it takes effect at the next reload.
- Simultaneous events (same edge):
  - CPU COUNT write vs tick: write wins.
  - CPU CTRL write vs one-shot EN clear: write wins.
  - W1C vs new expiry: set wins, so no event is lost.
- PORT_ID out of range with IO_STRB=1: no state change.

## Timing
- Reset values: CTRL, RELOAD, COUNT, EXPIRED and prescaler = 0. INTERRUPT=0. IN_PORT=0 while unselected, and reads 0 from every register while selected.
- RESET asserted mid-count clears all state immediately, asynchronously. The first tick after release requires EN to be written again.
- A write captured at edge N is visible on IN_PORT from cycle N+1. Read latency is 0 cycles (same cycle as PORT_ID), matching the MCU's IN execute cycle.
- EN 0->1 with PSC=0: the first tick occurs at edge N+1, where N is the CTRL write edge.
- EXPIRED and INTERRUPT rise in the cycle after the tick edge that sees COUNT==0.
- IO_STRB held for k cycles produces k writes. This is idempotent for every register except COUNT, which is reloaded each cycle.

## Configuration
- RAT_TIMER_PRESCALE_EN defined: 12-bit prescaler and CTRL.PSC implemented as above.
- Not defined: no prescaler is built; every cycle with EN=1 is a tick. CTRL bits[5:4] are ignored on write and read as 0.

## Test plan
- Reset then read ports 0x40–0x43 -> all 8'h00, INTERRUPT=0, IN_SEL=1. Read PORT_ID 0x44 -> IN_SEL=0, IN_PORT=8'h00.
- RELOAD=3, COUNT=3, CTRL=8'h07 (EN, AUTO, IE, PSC=0) -> COUNT reads 2,1,0,3,2… on successive cycles. EXPIRED and INTERRUPT rise in the cycle after COUNT reads 0 and stay high. Write STATUS 8'h01 -> INTERRUPT drops next cycle.
- One-shot: COUNT=2, CTRL=8'h05 -> EXPIRED=1 after 3 ticks, CTRL reads 8'h04, COUNT stays 0, STATUS reads 8'h01.
- Collisions: W1C STATUS on the same edge as an expiry -> EXPIRED remains 1. COUNT write of 8'h55 on a tick edge -> COUNT reads 8'h55.
- With RAT_TIMER_PRESCALE_EN, CTRL=8'h11 (PSC=1), COUNT=1 -> COUNT reads 0 exactly 16 cycles after the write edge. Without the macro -> COUNT reads 0 after 1 cycle, and CTRL reads 8'h01.
- Assert RESET asynchronously mid-count with INTERRUPT=1 -> INTERRUPT and all registers go to 0 before the next CLK edge.
